// File: rtl/cdr_phase_ctrl.sv
// Bang-bang CDR phase controller: votes early/late detector samples over fixed windows
// and steps a 10-bit phase-mixer code, with coarse acquisition and fine tracking modes.
module cdr_phase_ctrl #(
    parameter int         VOTE_LEN  = 16,
    parameter int         VOTE_TH   = 4,
    parameter int         STEP_ACQ  = 8,
    parameter int         STEP_TRK  = 1,
    parameter int         LOCK_CNT  = 8,
    parameter int         SLIP_CNT  = 4,
    parameter logic [9:0] INIT_CODE = 10'd0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Enable,
    input  logic       PD_Valid,
    input  logic       UP,
    input  logic       DN,
    output logic [9:0] Code,
    output logic       Code_Update,
    output logic       Locked
);

    localparam int SUM_MAX = (VOTE_LEN > VOTE_TH) ? VOTE_LEN : VOTE_TH;
    localparam int SW      = $clog2(SUM_MAX + 1) + 1;
    localparam int CW      = $clog2(VOTE_LEN + 1);
    localparam int RW      = $clog2(LOCK_CNT + 1);
    localparam int SLW     = $clog2(SLIP_CNT + 1);

    localparam logic signed [SW-1:0] TH_POS = SW'(VOTE_TH);
    localparam logic signed [SW-1:0] TH_NEG = -TH_POS;

    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

    state_t                state_q, state_d;
    dir_t                  prev_q, prev_d;
    dir_t                  moveDir;
    logic [9:0]            code_q, code_d;
    logic                  upd_q, upd_d;
    logic                  locked_q;
    logic signed [SW-1:0]  sum_q, sum_d;
    logic signed [SW-1:0]  voteInc, sumNext;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [RW-1:0]         rev_q, rev_d;
    logic [SLW-1:0]        slip_q, slip_d;
    logic [9:0]            step;
    logic                  lastSample;

    assign voteInc    = (UP && !DN) ? SW'(1) : ((DN && !UP) ? {SW{1'b1}} : '0);
    assign sumNext    = sum_q + voteInc;
    assign lastSample = (cnt_q == CW'(VOTE_LEN - 1));
    assign step       = (state_q == TRACK) ? 10'(STEP_TRK) : 10'(STEP_ACQ);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        upd_d   = 1'b0;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        rev_d   = rev_q;
        slip_d  = slip_q;
        prev_d  = prev_q;
        moveDir = DIR_NONE;
        case (state_q)
            IDLE: begin
                if (Enable) begin
                    state_d = ACQ;
                end
            end
            ACQ, TRACK: begin
                if (!Enable) begin
                    state_d = IDLE;
                    sum_d   = '0;
                    cnt_d   = '0;
                    rev_d   = '0;
                    slip_d  = '0;
                end else if (PD_Valid) begin
                    if (lastSample) begin
                        // The closing sample is part of the decision; the next window starts empty.
                        sum_d = '0;
                        cnt_d = '0;
                        if (sumNext >= TH_POS) begin
                            moveDir = DIR_UP;
                        end else if (sumNext <= TH_NEG) begin
                            moveDir = DIR_DN;
                        end
                        if (moveDir != DIR_NONE) begin
                            upd_d  = 1'b1;
                            prev_d = moveDir;
                            code_d = (moveDir == DIR_UP) ? (code_q + step) : (code_q - step);
                            if (state_q == ACQ) begin
                                if ((prev_q != DIR_NONE) && (prev_q != moveDir)) begin
                                    if (int'(rev_q) + 1 >= LOCK_CNT) begin
                                        state_d = TRACK;
                                        rev_d   = '0;
                                    end else begin
                                        rev_d = rev_q + RW'(1);
                                    end
                                end else begin
                                    rev_d = '0;
                                end
                            end else begin
                                if (prev_q == moveDir) begin
                                    if (int'(slip_q) + 1 >= SLIP_CNT) begin
                                        state_d = ACQ;
                                        slip_d  = '0;
                                    end else begin
                                        slip_d = slip_q + SLW'(1);
                                    end
                                end else begin
                                    slip_d = '0;
                                end
                            end
                        end
                    end else begin
                        sum_d = sumNext;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            prev_q   <= DIR_NONE;
            code_q   <= INIT_CODE;
            upd_q    <= 1'b0;
            locked_q <= 1'b0;
            sum_q    <= '0;
            cnt_q    <= '0;
            rev_q    <= '0;
            slip_q   <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            code_q   <= code_d;
            upd_q    <= upd_d;
            locked_q <= (state_d == TRACK);
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            rev_q    <= rev_d;
            slip_q   <= slip_d;
        end
    end

    assign Code        = code_q;
    assign Code_Update = upd_q;
    assign Locked      = locked_q;

endmodule

// File: tb/tb_cdr_phase_ctrl.sv
// Directed scoreboard bench for cdr_phase_ctrl: each vote window pushes its expected
// code/pulse/lock result, which is popped and compared in the decision cycle.
module tb_cdr_phase_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Enable;
    logic       PD_Valid;
    logic       UP;
    logic       DN;
    logic [9:0] Code;
    logic       Code_Update;
    logic       Locked;

    typedef struct {
        logic [9:0] code;
        logic       upd;
        logic       locked;
    } exp_t;

    exp_t       expQ[$];
    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;
    logic [9:0] expCode;

    cdr_phase_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .Enable      (Enable),
        .PD_Valid    (PD_Valid),
        .UP          (UP),
        .DN          (DN),
        .Code        (Code),
        .Code_Update (Code_Update),
        .Locked      (Locked)
    );

    always #5 CLK = ~CLK;

    // Count update pulses between the rising and falling edges, clear of the driver process.
    always begin
        @(posedge CLK);
        #2;
        if (Code_Update === 1'b1) pulses = pulses + 1;
    end

    initial begin
        #300000;
        $display("[TB] FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic u, input logic d);
        @(negedge CLK);
        PD_Valid = v;
        UP       = u;
        DN       = d;
    endtask

    task automatic driveN(input int n, input logic u, input logic d);
        for (int i = 0; i < n; i++) drive(1'b1, u, d);
    endtask

    // Interleaves the sample classes so every window ends on a valid sample.
    task automatic applyStimulus(input int nUp, input int nDn, input int nBoth, input int nNone,
                                 input int nGap, input int moveDir, input int step,
                                 input logic expLock);
        exp_t e;
        pulses = 0;
        while (nUp + nDn + nBoth + nNone + nGap > 0) begin
            if (nGap > 0)  begin drive(1'b0, 1'b1, 1'b0); nGap--;  end
            if (nUp > 0)   begin drive(1'b1, 1'b1, 1'b0); nUp--;   end
            if (nDn > 0)   begin drive(1'b1, 1'b0, 1'b1); nDn--;   end
            if (nBoth > 0) begin drive(1'b1, 1'b1, 1'b1); nBoth--; end
            if (nNone > 0) begin drive(1'b1, 1'b0, 1'b0); nNone--; end
        end
        if (moveDir > 0) expCode = expCode + 10'(step);
        else if (moveDir < 0) expCode = expCode - 10'(step);
        e.code   = expCode;
        e.upd    = (moveDir != 0);
        e.locked = expLock;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        @(negedge CLK);
        PD_Valid = 1'b0;
        UP       = 1'b0;
        DN       = 1'b0;
        if (expQ.size() == 0) begin
            checkVal({tag, "_queue"}, 32'(expQ.size()), 32'd1);
        end else begin
            e = expQ.pop_front();
            checkVal({tag, "_code"}, 32'(Code), 32'(e.code));
            checkVal({tag, "_upd"}, 32'(Code_Update), 32'(e.upd));
            checkVal({tag, "_pulses"}, 32'(pulses), e.upd ? 32'd1 : 32'd0);
            checkVal({tag, "_locked"}, 32'(Locked), 32'(e.locked));
        end
    endtask

    task automatic window(input string tag, input int dir, input int step, input logic lock);
        if (dir > 0) applyStimulus(16, 0, 0, 0, 0, 1, step, lock);
        else         applyStimulus(0, 16, 0, 0, 0, -1, step, lock);
        checkOutput(tag);
    endtask

    initial begin
        RST      = 1'b1;
        Enable   = 1'b0;
        PD_Valid = 1'b0;
        UP       = 1'b0;
        DN       = 1'b0;
        expCode  = 10'h000;
        repeat (2) @(negedge CLK);
        checkVal("rst_code", 32'(Code), 32'h000);
        checkVal("rst_upd", 32'(Code_Update), 32'd0);
        checkVal("rst_locked", 32'(Locked), 32'd0);
        RST    = 1'b0;
        Enable = 1'b1;

        window("first_up", 1, 8, 1'b0);
        applyStimulus(10, 6, 0, 0, 4, 1, 8, 1'b0);
        checkOutput("mix_plus4");
        applyStimulus(9, 6, 1, 0, 4, 0, 8, 1'b0);
        checkOutput("mix_plus3_hold");
        applyStimulus(4, 8, 0, 4, 0, -1, 8, 1'b0);
        checkOutput("mix_minus4");
        applyStimulus(3, 6, 2, 5, 2, 0, 8, 1'b0);
        checkOutput("mix_minus3_hold");

        // Reset in the middle of a window throws away the partial vote.
        driveN(12, 1'b1, 1'b0);
        @(negedge CLK);
        RST      = 1'b1;
        PD_Valid = 1'b0;
        UP       = 1'b0;
        @(negedge CLK);
        checkVal("midrst_code", 32'(Code), 32'h000);
        checkVal("midrst_locked", 32'(Locked), 32'd0);
        RST     = 1'b0;
        expCode = 10'h000;
        pulses  = 0;
        driveN(4, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        checkVal("postrst_4up_code", 32'(Code), 32'h000);
        checkVal("postrst_4up_pulses", 32'(pulses), 32'd0);
        applyStimulus(12, 0, 0, 0, 0, 1, 8, 1'b0);
        checkOutput("postrst_fill");

        window("pre_up", 1, 8, 1'b0);
        window("pre_dn1", -1, 8, 1'b0);
        window("pre_dn2", -1, 8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            window($sformatf("lock_alt%0d", i), (i % 2 == 0) ? 1 : -1, 8, (i == 7));
        end

        for (int i = 0; i < 4; i++) begin
            window($sformatf("slip_dn%0d", i), -1, 1, (i != 3));
        end
        window("slip_after", -1, 8, 1'b0);

        for (int i = 0; i < 33; i++) begin
            window($sformatf("climb%0d", i), 1, 8, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            window($sformatf("relock_alt%0d", i), (i % 2 == 0) ? -1 : 1, 8, (i == 7));
        end
        for (int i = 0; i < 4; i++) begin
            window($sformatf("trk_up%0d", i), 1, 1, (i != 3));
        end

        // Dropping Enable mid-window freezes the code and discards the partial vote.
        driveN(10, 1'b1, 1'b0);
        @(negedge CLK);
        Enable   = 1'b0;
        PD_Valid = 1'b1;
        UP       = 1'b1;
        DN       = 1'b0;
        pulses   = 0;
        repeat (3) @(negedge CLK);
        checkVal("dis_code", 32'(Code), 32'(expCode));
        checkVal("dis_locked", 32'(Locked), 32'd0);
        checkVal("dis_pulses", 32'(pulses), 32'd0);
        Enable   = 1'b1;
        PD_Valid = 1'b0;
        UP       = 1'b0;
        driveN(6, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        checkVal("reen_6up_code", 32'(Code), 32'(expCode));
        checkVal("reen_6up_pulses", 32'(pulses), 32'd0);
        applyStimulus(10, 0, 0, 0, 0, 1, 8, 1'b0);
        checkOutput("reen_fill");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdr_phase_ctrl.md
CDR_PHASE_CTRL -- requirements
Module: cdr_phase_ctrl

Interface
REQ-001 SHALL have parameter VOTE_LEN, default 16, the number of valid phase-detector samples per vote window.
REQ-002 SHALL have parameter VOTE_TH, default 4, the net-vote magnitude needed to move phase.
REQ-003 SHALL have parameter STEP_ACQ, default 8, the code step in ACQ.
REQ-004 SHALL have parameter STEP_TRK, default 1, the code step in TRACK.
REQ-005 SHALL have parameter LOCK_CNT, default 8, the consecutive direction reversals that declare lock.
REQ-006 SHALL have parameter SLIP_CNT, default 4, the consecutive same-direction moves that declare loss of lock.
REQ-007 SHALL have parameter INIT_CODE, default 10'd0, the code loaded at reset.
REQ-008 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-009 RST  input  1  reset; one clock; reset is synchronous and active-high.
REQ-010 Enable  input  1  loop enable; low freezes Code and votes.
REQ-011 PD_Valid  input  1  qualifies UP/DN this cycle.
REQ-012 UP  input  1  bang-bang detector vote: sampling clock late, advance phase.
REQ-013 DN  input  1  bang-bang detector vote: sampling clock early, retard phase.
REQ-014 Code  output  10  phase-mixer code: [9:8] quadrant select, [7:0] interpolation weight.
REQ-015 Code_Update  output  1  one-cycle pulse in the cycle Code changes.
REQ-016 Locked  output  1  high while in TRACK.

Function
REQ-017 SHALL implement states IDLE, ACQ, TRACK.
REQ-018 IDLE -> ACQ on the first cycle Enable=1; ACQ/TRACK -> IDLE whenever Enable=0, which also clears the vote counter, sample counter and the reversal/slip counters; Code holds.
REQ-019 Per cycle with PD_Valid=1 in ACQ/TRACK: UP&~DN adds +1 to the signed vote sum, DN&~UP adds -1, UP&DN or neither adds 0; the sample counter increments in all four cases.
REQ-020 Cycles with PD_Valid=0 SHALL change neither the vote sum nor the sample counter.
REQ-021 The window closes on the valid sample that brings the sample counter to VOTE_LEN; that sample SHALL be included in the decision.
REQ-022 Decision: sum >= VOTE_TH -> advance; sum <= -VOTE_TH -> retard; otherwise hold.
REQ-023 Code SHALL register the decision in the cycle after window close (1-cycle latency); Code_Update pulses in that same cycle for advance/retard only.
REQ-024 The vote sum and sample counter SHALL restart from 0 in the decision cycle, and a valid sample in that cycle SHALL count toward the new window.
REQ-025 Advance: Code = (Code + step) mod 1024; retard: Code = (Code - step) mod 1024; step = STEP_ACQ in ACQ and STEP_TRK in TRACK.
REQ-026 Quadrant carry/borrow SHALL follow from 10-bit wrap (e.g. 10'h0FF+1 = 10'h100; 10'h000-1 = 10'h3FF).
REQ-027 Reversal counter: increment on a move opposite to the previous move; reset to 0 on a same-direction move; unchanged on hold.
REQ-028 ACQ -> TRACK when the reversal counter reaches LOCK_CNT; the reversal counter then clears.
REQ-029 Slip counter, TRACK only: increment on a move in the same direction as the previous move; reset to 0 on a reversal; unchanged on hold.
REQ-030 TRACK -> ACQ when the slip counter reaches SLIP_CNT; the slip counter then clears.
REQ-031 The move that triggers a state change SHALL use the old state's step.
REQ-032 Locked SHALL be registered and equal (state == TRACK).
REQ-033 The vote sum SHALL be wide enough for +/-VOTE_LEN without overflow.

Reset
REQ-034 RST=1 at a rising edge SHALL force state IDLE, Code=INIT_CODE, Code_Update=0, Locked=0, and all counters and previous-direction memory to 0/none.
REQ-035 RST SHALL take priority over Enable and any in-flight window; a partial window is discarded.

Verification
REQ-036 Reset, then Enable=1 with 16 valid UP-only samples -> Code 0 -> 8 one cycle after the 16th sample; Code_Update pulses once; Locked=0.
REQ-037 Defaults, Code=10'h0FC in TRACK, one all-UP window -> Code=10'h0FD; with Code=10'h000, one all-DN window -> Code=10'h3FF.
REQ-038 In ACQ, alternate all-UP and all-DN windows 8 times -> Locked rises one cycle after the 8th decision; Code dithers by +/-8.
REQ-039 In TRACK, 4 consecutive all-DN windows -> Code drops by 4 and Locked falls with the 4th move; the next all-DN window steps by 8.
REQ-040 Window of 10 UP, 6 DN, interleaved PD_Valid=0 cycles and UP&DN cycles -> net +4 -> advance; net +3 -> hold with no Code_Update.
REQ-041 RST asserted mid-window after 12 UP samples -> Code=INIT_CODE, IDLE; after re-enable, 4 UP samples produce no move.
